// File: rtl/varicode_pkg.sv
// varicode_pkg: shared widths, ASCII constants, code record and helpers for the varicode decoder
package varicode_pkg;
    localparam int WORD_W       = 13;
    localparam int ACC_W        = 12;
    localparam int LEN_W        = 4;
    localparam int MAX_CODE_LEN = 10;
    localparam logic [6:0] ASCII_SP = 7'h20;
    localparam logic [6:0] ASCII_A  = 7'h61;
    localparam logic [6:0] ASCII_E  = 7'h65;
    localparam logic [6:0] ASCII_T  = 7'h74;
    typedef struct packed {
        logic [ACC_W-1:0] code;
        logic [LEN_W-1:0] len;
    } code_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_HOLD} tx_state_t;
    function automatic logic [7:0] sat_inc(logic [7:0] v);
        return v + {7'd0, v != 8'hff};
    endfunction
endpackage

// File: rtl/varicode_rom.sv
// varicode_rom: PSK31 varicode to 7-bit ASCII lookup; code is right-aligned, len disambiguates width
module varicode_rom
    import varicode_pkg::*;
(
    input  logic [ACC_W-1:0] code,
    input  logic [LEN_W-1:0] len,
    output logic [6:0]       ascii,
    output logic             hit
);
    always_comb begin
        ascii = 7'h00;
        hit   = 1'b1;
        case ({len, code})
            {4'd10, 12'b1010101011}: ascii = 7'h00;  {4'd10, 12'b1011011011}: ascii = 7'h01;
            {4'd10, 12'b1011101101}: ascii = 7'h02;  {4'd10, 12'b1101110111}: ascii = 7'h03;
            {4'd10, 12'b1011101011}: ascii = 7'h04;  {4'd10, 12'b1101011111}: ascii = 7'h05;
            {4'd10, 12'b1011101111}: ascii = 7'h06;  {4'd10, 12'b1011111101}: ascii = 7'h07;
            {4'd10, 12'b1011111111}: ascii = 7'h08;  {4'd8,  12'b11101111}:   ascii = 7'h09;
            {4'd5,  12'b11101}:      ascii = 7'h0A;  {4'd10, 12'b1101101111}: ascii = 7'h0B;
            {4'd10, 12'b1011011101}: ascii = 7'h0C;  {4'd5,  12'b11111}:      ascii = 7'h0D;
            {4'd10, 12'b1101110101}: ascii = 7'h0E;  {4'd10, 12'b1110101011}: ascii = 7'h0F;
            {4'd10, 12'b1011110111}: ascii = 7'h10;  {4'd10, 12'b1011110101}: ascii = 7'h11;
            {4'd10, 12'b1110101101}: ascii = 7'h12;  {4'd10, 12'b1110101111}: ascii = 7'h13;
            {4'd10, 12'b1101011011}: ascii = 7'h14;  {4'd10, 12'b1101101011}: ascii = 7'h15;
            {4'd10, 12'b1101101101}: ascii = 7'h16;  {4'd10, 12'b1101010111}: ascii = 7'h17;
            {4'd10, 12'b1101111011}: ascii = 7'h18;  {4'd10, 12'b1101111101}: ascii = 7'h19;
            {4'd10, 12'b1110110111}: ascii = 7'h1A;  {4'd10, 12'b1101010101}: ascii = 7'h1B;
            {4'd10, 12'b1101011101}: ascii = 7'h1C;  {4'd10, 12'b1110111011}: ascii = 7'h1D;
            {4'd10, 12'b1011111011}: ascii = 7'h1E;  {4'd10, 12'b1101111111}: ascii = 7'h1F;
            {4'd1,  12'b1}:          ascii = 7'h20;  {4'd9,  12'b111111111}:  ascii = 7'h21;
            {4'd9,  12'b101011111}:  ascii = 7'h22;  {4'd9,  12'b111110101}:  ascii = 7'h23;
            {4'd9,  12'b111011011}:  ascii = 7'h24;  {4'd10, 12'b1011010101}: ascii = 7'h25;
            {4'd10, 12'b1010111011}: ascii = 7'h26;  {4'd9,  12'b101111111}:  ascii = 7'h27;
            {4'd8,  12'b11111011}:   ascii = 7'h28;  {4'd8,  12'b11110111}:   ascii = 7'h29;
            {4'd9,  12'b101101111}:  ascii = 7'h2A;  {4'd9,  12'b111011111}:  ascii = 7'h2B;
            {4'd7,  12'b1110101}:    ascii = 7'h2C;  {4'd6,  12'b110101}:     ascii = 7'h2D;
            {4'd7,  12'b1010111}:    ascii = 7'h2E;  {4'd9,  12'b110101111}:  ascii = 7'h2F;
            {4'd8,  12'b10110111}:   ascii = 7'h30;  {4'd8,  12'b10111101}:   ascii = 7'h31;
            {4'd8,  12'b11101101}:   ascii = 7'h32;  {4'd8,  12'b11111111}:   ascii = 7'h33;
            {4'd9,  12'b101110111}:  ascii = 7'h34;  {4'd9,  12'b101011011}:  ascii = 7'h35;
            {4'd9,  12'b101101011}:  ascii = 7'h36;  {4'd9,  12'b110101101}:  ascii = 7'h37;
            {4'd9,  12'b110101011}:  ascii = 7'h38;  {4'd9,  12'b110110111}:  ascii = 7'h39;
            {4'd8,  12'b11110101}:   ascii = 7'h3A;  {4'd9,  12'b110111101}:  ascii = 7'h3B;
            {4'd9,  12'b111101101}:  ascii = 7'h3C;  {4'd7,  12'b1010101}:    ascii = 7'h3D;
            {4'd9,  12'b111010111}:  ascii = 7'h3E;  {4'd10, 12'b1010101111}: ascii = 7'h3F;
            {4'd10, 12'b1010111101}: ascii = 7'h40;  {4'd7,  12'b1111101}:    ascii = 7'h41;
            {4'd8,  12'b11101011}:   ascii = 7'h42;  {4'd8,  12'b10101101}:   ascii = 7'h43;
            {4'd8,  12'b10110101}:   ascii = 7'h44;  {4'd7,  12'b1110111}:    ascii = 7'h45;
            {4'd8,  12'b11011011}:   ascii = 7'h46;  {4'd8,  12'b11111101}:   ascii = 7'h47;
            {4'd9,  12'b101010101}:  ascii = 7'h48;  {4'd7,  12'b1111111}:    ascii = 7'h49;
            {4'd9,  12'b111111101}:  ascii = 7'h4A;  {4'd9,  12'b101111101}:  ascii = 7'h4B;
            {4'd8,  12'b11010111}:   ascii = 7'h4C;  {4'd8,  12'b10111011}:   ascii = 7'h4D;
            {4'd8,  12'b11011101}:   ascii = 7'h4E;  {4'd8,  12'b10101011}:   ascii = 7'h4F;
            {4'd8,  12'b11010101}:   ascii = 7'h50;  {4'd9,  12'b111011101}:  ascii = 7'h51;
            {4'd8,  12'b10101111}:   ascii = 7'h52;  {4'd7,  12'b1101111}:    ascii = 7'h53;
            {4'd7,  12'b1101101}:    ascii = 7'h54;  {4'd9,  12'b101010111}:  ascii = 7'h55;
            {4'd9,  12'b110110101}:  ascii = 7'h56;  {4'd9,  12'b101011101}:  ascii = 7'h57;
            {4'd9,  12'b101110101}:  ascii = 7'h58;  {4'd9,  12'b101111011}:  ascii = 7'h59;
            {4'd10, 12'b1010101101}: ascii = 7'h5A;  {4'd9,  12'b111110111}:  ascii = 7'h5B;
            {4'd9,  12'b111101111}:  ascii = 7'h5C;  {4'd9,  12'b111111011}:  ascii = 7'h5D;
            {4'd10, 12'b1010111111}: ascii = 7'h5E;  {4'd9,  12'b101101101}:  ascii = 7'h5F;
            {4'd10, 12'b1011011111}: ascii = 7'h60;  {4'd4,  12'b1011}:       ascii = 7'h61;
            {4'd7,  12'b1011111}:    ascii = 7'h62;  {4'd6,  12'b101111}:     ascii = 7'h63;
            {4'd6,  12'b101101}:     ascii = 7'h64;  {4'd2,  12'b11}:         ascii = 7'h65;
            {4'd6,  12'b111101}:     ascii = 7'h66;  {4'd7,  12'b1011011}:    ascii = 7'h67;
            {4'd6,  12'b101011}:     ascii = 7'h68;  {4'd4,  12'b1101}:       ascii = 7'h69;
            {4'd9,  12'b111101011}:  ascii = 7'h6A;  {4'd8,  12'b10111111}:   ascii = 7'h6B;
            {4'd5,  12'b11011}:      ascii = 7'h6C;  {4'd6,  12'b111011}:     ascii = 7'h6D;
            {4'd4,  12'b1111}:       ascii = 7'h6E;  {4'd3,  12'b111}:        ascii = 7'h6F;
            {4'd6,  12'b111111}:     ascii = 7'h70;  {4'd9,  12'b110111111}:  ascii = 7'h71;
            {4'd5,  12'b10101}:      ascii = 7'h72;  {4'd5,  12'b10111}:      ascii = 7'h73;
            {4'd3,  12'b101}:        ascii = 7'h74;  {4'd6,  12'b110111}:     ascii = 7'h75;
            {4'd7,  12'b1111011}:    ascii = 7'h76;  {4'd7,  12'b1101011}:    ascii = 7'h77;
            {4'd8,  12'b11011111}:   ascii = 7'h78;  {4'd7,  12'b1011101}:    ascii = 7'h79;
            {4'd9,  12'b111010101}:  ascii = 7'h7A;  {4'd10, 12'b1010110111}: ascii = 7'h7B;
            {4'd9,  12'b110111011}:  ascii = 7'h7C;  {4'd10, 12'b1010110101}: ascii = 7'h7D;
            {4'd10, 12'b1011010111}: ascii = 7'h7E;  {4'd10, 12'b1110110101}: ascii = 7'h7F;
            default: hit = 1'b0;
        endcase
    end
endmodule

// File: rtl/varicode_decoder.sv
// varicode_decoder: serialises UART symbol words, decodes PSK31 varicode and queues
// the ASCII result for the UART transmitter with a start/busy handshake.
module varicode_decoder
    import varicode_pkg::*;
#(
    parameter int FIFO_DEPTH   = 16,
    parameter int MAX_CODE_LEN = 10,
    parameter int HOLDOFF      = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [12:0] in_word,
    output logic        in_ready,
    input  logic        tx_busy,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic [7:0]  word_drop_cnt,
    output logic [7:0]  char_drop_cnt,
    output logic [7:0]  invalid_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    logic [WORD_W-1:0] sh;
    logic [3:0]        bit_cnt;
    code_t             acc;
    logic              zero_run, too_long;
    logic [1:0]        add;
    logic [4:0]        new_len;
    logic              bit_vld, cur, sep;
    logic [6:0]        rom_ascii, res_ascii;
    logic              rom_hit, res_vld, res_ok;
    logic [6:0]        mem [FIFO_DEPTH];
    logic [AW:0]       wr_ptr, rd_ptr;
    logic              empty, full, push, pop;
    tx_state_t         state, state_nx;
    logic [7:0]        hold_cnt;

    assign bit_vld = !in_ready;
    assign cur     = sh[0];
    // the pending zero only belongs to the code when something is already accumulated
    assign add     = (zero_run && acc.len != '0) ? 2'd2 : 2'd1;
    assign new_len = {1'b0, acc.len} + {3'b0, add};
    assign sep     = bit_vld && !cur && zero_run && acc.len != '0;
    assign empty   = wr_ptr == rd_ptr;
    assign full    = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
    assign pop     = state == TX_IDLE && !empty && !tx_busy;
    assign push    = res_vld && res_ok && (!full || pop);
    assign tx_start = state == TX_START;

    varicode_rom u_rom (.code(acc.code), .len(acc.len), .ascii(rom_ascii), .hit(rom_hit));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh            <= '0;
            bit_cnt       <= '0;
            in_ready      <= 1'b1;
            word_drop_cnt <= '0;
        end else begin
            if (in_valid && in_ready) begin
                sh       <= in_word;
                bit_cnt  <= '0;
                in_ready <= 1'b0;
            end else if (!in_ready) begin
                sh       <= sh >> 1;
                bit_cnt  <= bit_cnt + 4'd1;
                in_ready <= bit_cnt == 4'(WORD_W - 1);
            end
            if (in_valid && !in_ready) word_drop_cnt <= sat_inc(word_drop_cnt);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            zero_run  <= 1'b0;
            too_long  <= 1'b0;
            res_vld   <= 1'b0;
            res_ok    <= 1'b0;
            res_ascii <= '0;
        end else begin
            if (bit_vld && cur) begin
                zero_run <= 1'b0;
                if (too_long || new_len > 5'(ACC_W)) too_long <= 1'b1;
                else acc <= '{code: (acc.code << add) | 12'd1, len: new_len[3:0]};
            end else if (bit_vld && !zero_run) begin
                zero_run <= 1'b1;
            end else if (sep) begin
                acc      <= '0;
                too_long <= 1'b0;
            end
            res_vld   <= sep;
            res_ascii <= rom_ascii;
            res_ok    <= rom_hit && !too_long && 32'(acc.len) <= MAX_CODE_LEN;
        end
    end

    always_ff @(posedge clk) if (push) mem[wr_ptr[AW-1:0]] <= res_ascii;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            tx_data       <= '0;
            invalid_cnt   <= '0;
            char_drop_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                tx_data <= {1'b0, mem[rd_ptr[AW-1:0]]};
            end
            if (res_vld && !res_ok) invalid_cnt <= sat_inc(invalid_cnt);
            if (res_vld && res_ok && full && !pop) char_drop_cnt <= sat_inc(char_drop_cnt);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= TX_IDLE;
            hold_cnt <= '0;
        end else begin
            state    <= state_nx;
            hold_cnt <= state == TX_HOLD ? hold_cnt + 8'd1 : 8'd0;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            TX_IDLE:  state_nx = pop ? TX_START : TX_IDLE;
            TX_START: state_nx = HOLDOFF == 0 ? TX_IDLE : TX_HOLD;
            TX_HOLD:  state_nx = hold_cnt == 8'(HOLDOFF - 1) ? TX_IDLE : TX_HOLD;
            default:  state_nx = TX_IDLE;
        endcase
    end
endmodule
